// File: rtl/subtrator_serial_if.sv
// Start/busy/done bundle for the bit-serial subtractor.
// ovf exists only when SUBTRATOR_SERIAL_OVF_EN is defined.
interface subtrator_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial a - b, LSB first, N+1 cycles per op.
// Optional signed overflow flag: SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  subtrator_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(N);

  state_t       state;
  logic [N-1:0] sa;
  logic [N-1:0] sb;
  logic [N-1:0] res;
  logic         br;
  logic [CW-1:0] cnt;
  logic         d;
  logic         br_nx;

  // two cascaded half-subtractors
  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0])
          | (~(sa[0] ^ sb[0]) & br);
  end

`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic am;
  logic bm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      am      <= 1'b0;
      bm      <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        am <= bus.a[N-1];
        bm <= bus.b[N-1];
      end
      if (state == DONE)
        bus.ovf <= (am ^ bm) & (res[N-1] ^ am);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sa             <= '0;
      sb             <= '0;
      res            <= '0;
      br             <= 1'b0;
      cnt            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.b;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res <= {d, res[N-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done       <= 1'b1;
          bus.diff       <= res;
          bus.borrow_out <= br;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed + exhaustive bench for subtrator_serial (N=8 and N=4).
// Expected results come from a queue scoreboard fed at stimulus time.
module tb_subtrator_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  subtrator_serial_if #(.N(8)) i8 ();
  subtrator_serial_if #(.N(4)) i4 ();

  subtrator_serial #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(i8.slave)
  );
  subtrator_serial #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(i4.slave)
  );

  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model8(
    input int a, input int b);
    logic [7:0] d;
    d = 8'((a - b) & 255);
    return {logic'(a < b), d};
  endfunction

  // start one op; returns latency and busy-cycle count
  task automatic op8(input int a, input int b,
                     input string tag,
                     output int lat, output int nb);
    bit got;
    i8.a = 8'(a);
    i8.b = 8'(b);
    i8.start = 1'b1;
    sb_q.push_back(model8(a, b));
    tick();
    i8.start = 1'b0;
    lat = 0;
    nb = 0;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (i8.busy) nb++;
      if (i8.done) begin
        got = 1;
        lat = k;
        break;
      end
      tick();
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got && sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      chk({tag, "_diff"}, 32'(i8.diff), 32'(exp_v[7:0]));
      chk({tag, "_borrow"}, 32'(i8.borrow_out),
          32'(exp_v[8]));
    end
    tick();
  endtask

  int lat, nb, nd, first, prev;
  bit got;

  initial begin
    i8.start = 0; i8.a = '0; i8.b = '0;
    i4.start = 0; i4.a = '0; i4.b = '0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_busy", 32'(i8.busy), 0);
    chk("rst_done", 32'(i8.done), 0);
    chk("rst_diff", 32'(i8.diff), 0);
    chk("rst_borrow", 32'(i8.borrow_out), 0);
    tick();

    op8(100, 37, "t1", lat, nb);
    chk("t1_latency", 32'(lat), 9);
    chk("t1_busy_cycles", 32'(nb), 8);
    op8(5, 10, "t2a", lat, nb);
    op8(0, 255, "t2b", lat, nb);
    op8(8'hA5, 8'hA5, "t2c", lat, nb);
    op8(255, 0, "t2d", lat, nb);

    // start pulsed during RUN must be ignored
    i8.a = 8'd200; i8.b = 8'd3;
    i8.start = 1;
    sb_q.push_back(model8(200, 3));
    tick();
    i8.start = 0;
    tick(); tick();
    i8.a = 8'd1; i8.b = 8'd1; i8.start = 1;
    tick();
    i8.start = 0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (i8.done) begin
        nd++;
        if (sb_q.size() > 0) begin
          exp_v = sb_q.pop_front();
          chk("t3_diff", 32'(i8.diff), 32'(exp_v[7:0]));
          chk("t3_borrow", 32'(i8.borrow_out),
              32'(exp_v[8]));
        end
      end
      tick();
    end
    chk("t3_done_count", 32'(nd), 1);

    // reset mid-RUN discards the op
    i8.a = 8'd77; i8.b = 8'd22; i8.start = 1;
    tick();
    i8.start = 0;
    tick(); tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t4_busy", 32'(i8.busy), 0);
    chk("t4_done", 32'(i8.done), 0);
    chk("t4_diff", 32'(i8.diff), 0);
    chk("t4_borrow", 32'(i8.borrow_out), 0);
    op8(77, 22, "t4_after", lat, nb);

    // start held high: one op per 10 cycles
    i8.a = 8'd200; i8.b = 8'd100; i8.start = 1;
    for (int j = 0; j < 3; j++) sb_q.push_back(model8(200, 100));
    nd = 0; first = -1; prev = -1;
    for (int k = 0; k < 60 && nd < 3; k++) begin
      tick();
      if (i8.done) begin
        exp_v = sb_q.pop_front();
        chk("t5_diff", 32'(i8.diff), 32'(exp_v[7:0]));
        if (prev >= 0)
          chk("t5_period", 32'(k - prev), 10);
        prev = k;
        nd++;
        if (nd == 3) i8.start = 0;
      end else if (prev >= 0) begin
        chk("t5_stable", 32'(i8.diff), 100);
      end
    end
    i8.start = 0;
    chk("t5_done_count", 32'(nd), 3);
    sb_q.delete();
    for (int k = 0; k < 12; k++) tick();

`ifdef SUBTRATOR_SERIAL_OVF_EN
    op8(8'h80, 8'h01, "t6a", lat, nb);
    chk("t6a_ovf", 32'(i8.ovf), 1);
    op8(8'h7F, 8'hFF, "t6b", lat, nb);
    chk("t6b_ovf", 32'(i8.ovf), 1);
    op8(8'h10, 8'h01, "t6c", lat, nb);
    chk("t6c_ovf", 32'(i8.ovf), 0);
`endif

    // exhaustive N=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        i4.a = 4'(a); i4.b = 4'(b); i4.start = 1;
        sb_q.push_back({logic'(a < b), 4'b0, 4'((a - b) & 15)});
        tick();
        i4.start = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
          if (i4.done) begin
            got = 1;
            break;
          end
          tick();
        end
        exp_v = sb_q.pop_front();
        if (got)
          chk("n4_pair", 32'({i4.borrow_out, i4.diff}),
              32'({exp_v[8], exp_v[3:0]}));
        else
          chk("n4_timeout", 32'(got), 1);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
